// File: rtl/snn_pkg.sv
// Shared definitions for the SNN front end: image loader state encoding and
// default frame geometry (98 bytes = 784 one-bit pixels, 10-bit pixel address).
package snn_pkg;

  localparam int NUM_BYTES_DEF = 98;
  localparam int ADDR_W_DEF    = 10;

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_UNPACK,
    ST_START,
    ST_BUSY
  } loader_state_t;

endpackage

// File: rtl/image_loader.sv
// Unpacks UART bytes LSB-first into a 1-bit pixel RAM, starts the SNN core when a
// frame is complete and hands the RAM address port to the core until it is done.
module image_loader
  import snn_pkg::*;
#(
  parameter int NUM_BYTES = NUM_BYTES_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic              core_done,
  output logic              ram_we,
  output logic              ram_d,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              start_core,
  output logic              overrun
);

  // Loader address is {byte count, bit index}, i.e. 8 x count + bit.
  localparam int              CNT_W     = ADDR_W - 3;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NUM_BYTES - 1);

  loader_state_t    state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [2:0]       bit_reg, bit_next;
  logic [7:0]       shift_reg, shift_next;
  logic [7:0]       buf_reg, buf_next;
  logic             buf_valid_reg, buf_valid_next;
  logic             overrun_reg, overrun_next;
  logic             last_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_WAIT;
      count_reg     <= '0;
      bit_reg       <= '0;
      shift_reg     <= '0;
      buf_reg       <= '0;
      buf_valid_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      bit_reg       <= bit_next;
      shift_reg     <= shift_next;
      buf_reg       <= buf_next;
      buf_valid_reg <= buf_valid_next;
      overrun_reg   <= overrun_next;
    end
  end

  assign last_bit = (bit_reg == 3'd7);

  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    bit_next       = bit_reg;
    shift_next     = shift_reg;
    buf_next       = buf_reg;
    buf_valid_next = buf_valid_reg;
    overrun_next   = overrun_reg;

    case (state_reg)
      ST_WAIT: begin
        if (rx_rdy) begin
          shift_next = rx_data;
          bit_next   = 3'd0;
          state_next = ST_UNPACK;
        end
      end

      ST_UNPACK: begin
        shift_next = {1'b0, shift_reg[7:1]};
        bit_next   = bit_reg + 3'd1;
        if (last_bit && (count_reg != LAST_BYTE)) begin
          // Byte boundary inside the frame: chain the next byte with no idle cycle.
          count_next = count_reg + 1'b1;
          if (buf_valid_reg) begin
            shift_next = buf_reg;
            if (rx_rdy) buf_next = rx_data;
            else        buf_valid_next = 1'b0;
          end else if (rx_rdy) begin
            shift_next = rx_data;
          end else begin
            state_next = ST_WAIT;
          end
        end else begin
          if (last_bit) state_next = ST_START;
          if (rx_rdy) begin
            if (buf_valid_reg) begin
              overrun_next = 1'b1;
            end else begin
              buf_next       = rx_data;
              buf_valid_next = 1'b1;
            end
          end
        end
      end

      ST_START: begin
        // Anything still pending belongs to no frame and is discarded.
        if (buf_valid_reg || rx_rdy) overrun_next = 1'b1;
        buf_valid_next = 1'b0;
        state_next     = ST_BUSY;
      end

      ST_BUSY: begin
        if (rx_rdy) overrun_next = 1'b1;
        if (core_done) begin
          state_next     = ST_WAIT;
          count_next     = '0;
          bit_next       = '0;
          buf_valid_next = 1'b0;
          overrun_next   = 1'b0;
        end
      end

      default: state_next = ST_WAIT;
    endcase
  end

  assign ram_we     = (state_reg == ST_UNPACK);
  assign ram_d      = ram_we & shift_reg[0];
  assign ram_addr   = (state_reg == ST_BUSY) ? core_addr : {count_reg, bit_reg};
  assign start_core = (state_reg == ST_START);
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_image_loader.sv
// Directed bench for image_loader: frame loading, back-to-back bytes, overrun,
// core handover and mid-frame reset, checked against hand-computed values.
module tb_image_loader;

  localparam int NUM_BYTES = 98;
  localparam int ADDR_W    = 10;
  localparam int NPIX      = NUM_BYTES * 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              rx_rdy;
  logic [7:0]        rx_data;
  logic [ADDR_W-1:0] core_addr;
  logic              core_done;
  logic              ram_we;
  logic              ram_d;
  logic [ADDR_W-1:0] ram_addr;
  logic              start_core;
  logic              overrun;

  int n_checks = 0;
  int n_errors = 0;

  // Bench-side picture of what the RAM received.
  logic mem [0:NPIX-1];
  int   wr_cnt, start_cnt, run, max_run, exp_addr, addr_err, last_addr;
  logic clr_req = 1'b0;

  image_loader #(.NUM_BYTES(NUM_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .core_addr(core_addr), .core_done(core_done), .ram_we(ram_we),
    .ram_d(ram_d), .ram_addr(ram_addr), .start_core(start_core),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (clr_req) begin
      wr_cnt <= 0; start_cnt <= 0; run <= 0; max_run <= 0;
      exp_addr <= 0; addr_err <= 0; last_addr <= 0;
    end else begin
      if (start_core) start_cnt <= start_cnt + 1;
      if (ram_we) begin
        run <= run + 1;
        if (run + 1 > max_run) max_run <= run + 1;
        if ((int'(ram_addr) != exp_addr) || (int'(ram_addr) >= NPIX)) addr_err <= addr_err + 1;
        else mem[ram_addr] <= ram_d;
        exp_addr  <= exp_addr + 1;
        wr_cnt    <= wr_cnt + 1;
        last_addr <= int'(ram_addr);
      end else begin
        run <= 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("  ok   %s = %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] d);
    rx_rdy  = 1'b1;
    rx_data = d;
    tick();
    rx_rdy  = 1'b0;
  endtask

  task automatic clear_stats();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   w0, ones, bad;
    logic [7:0] b;

    rst_n = 1'b0; rx_rdy = 1'b0; rx_data = '0; core_addr = '0; core_done = 1'b0;
    wait_cycles(3);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_d", ram_d, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_start", start_core, 0);
    check("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    clear_stats();

    // Full frame of 0xA5, bytes 100 cycles apart.
    for (int k = 0; k < NUM_BYTES; k++) begin
      send(8'hA5);
      if (k == 0) begin
        check("lat_we", ram_we, 1);
        check("lat_addr", ram_addr, 0);
        check("lat_d", ram_d, 1);
      end
      wait_cycles(99);
    end
    check("f1_writes", wr_cnt, NPIX);
    check("f1_last_addr", last_addr, NPIX - 1);
    check("f1_starts", start_cnt, 1);
    check("f1_overrun", overrun, 0);
    check("f1_addr_err", addr_err, 0);
    check("f1_mem0", mem[0], 1);
    check("f1_mem1", mem[1], 0);
    check("f1_mem2", mem[2], 1);
    check("f1_mem783", mem[NPIX-1], 1);

    // Core owns the RAM: byte dropped, address passed through.
    core_addr = 10'h155;
    send(8'h33);
    check("busy_addr", ram_addr, 10'h155);
    check("busy_we", ram_we, 0);
    check("busy_overrun", overrun, 1);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    core_addr = '0;
    check("done_overrun", overrun, 0);
    check("done_addr", ram_addr, 0);
    clear_stats();

    // 0x01 then 0x80 three cycles later: 16 writes with no gap.
    send(8'h01);
    check("nf_we", ram_we, 1);
    check("nf_addr", ram_addr, 0);
    wait_cycles(2);
    send(8'h80);
    wait_cycles(20);
    check("b2b_run", max_run, 16);
    check("b2b_writes", wr_cnt, 16);
    check("b2b_mem0", mem[0], 1);
    check("b2b_mem15", mem[15], 1);
    ones = 0;
    for (int a = 1; a < 15; a++) if (mem[a]) ones++;
    check("b2b_mid_ones", ones, 0);

    // core_done outside BUSY is ignored, then three consecutive pulses.
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    w0 = wr_cnt;
    rx_rdy = 1'b1;
    rx_data = 8'hFF; tick();
    rx_data = 8'h3C; tick();
    rx_data = 8'h77; tick();
    rx_rdy = 1'b0;
    wait_cycles(30);
    check("ovr_writes", wr_cnt - w0, 16);
    check("ovr_flag", overrun, 1);
    check("ovr_last_addr", last_addr, 31);
    check("ovr_mem16", mem[16], 1);
    check("ovr_mem24", mem[24], 0);
    check("ovr_mem26", mem[26], 1);
    check("ovr_addr_err", addr_err, 0);

    // Bring the frame to 40 bytes, reset while the last one is unpacking.
    for (int k = 0; k < 35; k++) begin
      send(8'h5A);
      wait_cycles(11);
    end
    send(8'h5A);
    wait_cycles(3);
    check("pre_rst_addr_err", addr_err, 0);
    check("pre_rst_overrun", overrun, 1);
    rst_n = 1'b0;
    #1;
    check("mrst_we", ram_we, 0);
    check("mrst_d", ram_d, 0);
    check("mrst_addr", ram_addr, 0);
    check("mrst_start", start_core, 0);
    check("mrst_overrun", overrun, 0);
    tick();
    rst_n = 1'b1;
    tick();
    clear_stats();

    // Fresh frame, each byte arriving on the previous byte's last-bit cycle.
    for (int k = 0; k < NUM_BYTES; k++) begin
      if (k == NUM_BYTES - 1) check("f2_no_early_start", start_cnt, 0);
      send(8'(k) ^ 8'h5A);
      if (k < NUM_BYTES - 1) wait_cycles(7);
    end
    wait_cycles(20);
    check("f2_starts", start_cnt, 1);
    check("f2_writes", wr_cnt, NPIX);
    check("f2_run", max_run, NPIX);
    check("f2_last_addr", last_addr, NPIX - 1);
    check("f2_overrun", overrun, 0);
    check("f2_addr_err", addr_err, 0);
    bad = 0;
    for (int a = 0; a < NPIX; a++) begin
      b = 8'(a / 8) ^ 8'h5A;
      if (mem[a] !== b[a % 8]) bad++;
    end
    check("f2_bits", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/image_loader.md
IMAGE_LOADER -- requirements
Module: image_loader

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 98, meaning image bytes per frame (98 x 8 = 784 pixels).
REQ-002 SHALL have parameter ADDR_W, default 10, meaning width of the pixel RAM address.
REQ-003 SHALL have port clk  input  1  system clock, all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rx_rdy  input  1  one-cycle pulse: UART receiver has a new byte.
REQ-006 SHALL have port rx_data  input  8  received byte, valid while rx_rdy=1.
REQ-007 SHALL have port core_addr  input  ADDR_W  pixel address driven by the SNN core.
REQ-008 SHALL have port core_done  input  1  one-cycle pulse: core has finished classification.
REQ-009 SHALL have port ram_we  output  1  write enable to the 1-bit-wide pixel RAM.
REQ-010 SHALL have port ram_d  output  1  pixel bit written to RAM.
REQ-011 SHALL have port ram_addr  output  ADDR_W  RAM address: loader address, or core_addr while the core owns the RAM.
REQ-012 SHALL have port start_core  output  1  one-cycle pulse: frame complete, core may start.
REQ-013 SHALL have port overrun  output  1  sticky flag: a received byte was dropped.

Function
REQ-014 SHALL implement states WAIT, UNPACK, START, BUSY.
REQ-015 WAIT: rx_rdy=1 SHALL latch rx_data into a shift register and enter UNPACK on the next cycle.
REQ-016 UNPACK SHALL write one bit per cycle for 8 cycles, LSB first: bit i of byte k goes to address 8k+i, with ram_we=1 in each cycle.
REQ-017 Latency: rx_rdy at cycle T SHALL produce writes in cycles T+1 through T+8.
REQ-018 UNPACK SHALL accept rx_rdy into a one-entry holding buffer; when the current byte ends with the buffer valid, the buffered byte SHALL start unpacking in the next cycle without an idle cycle.
REQ-019 rx_rdy while the buffer is already full SHALL drop the new byte and set overrun.
REQ-020 rx_rdy in the same cycle the last bit of a byte is written SHALL be captured into the buffer, not lost.
REQ-021 A byte counter (0..NUM_BYTES-1) SHALL increment after each byte's 8th bit; the write address SHALL equal 8 x count + bit index and never exceed 8 x NUM_BYTES - 1.
REQ-022 After the last bit of byte NUM_BYTES-1, SHALL enter START: start_core=1 for exactly one cycle, then enter BUSY.
REQ-023 BUSY: ram_we=0, ram_addr=core_addr; rx_rdy SHALL be dropped and set overrun, including any byte left in the holding buffer at frame end.
REQ-024 In all states except BUSY, ram_addr SHALL be the loader address.
REQ-025 BUSY: core_done SHALL clear the byte counter and buffer and return to WAIT on the next cycle.
REQ-026 core_done outside BUSY SHALL be ignored.
REQ-027 Leaving BUSY SHALL clear overrun; otherwise overrun SHALL be cleared only by reset.
REQ-028 rx_rdy and core_done in the same BUSY cycle: the byte SHALL be dropped (overrun=1, then cleared on exit), and the state SHALL become WAIT.

Reset
REQ-029 rst_n=0 SHALL, at any time including mid-frame, force state WAIT, counter 0, bit index 0, buffer empty, ram_we=0, ram_d=0, ram_addr=0, start_core=0, overrun=0.
REQ-030 Bits written before a mid-frame reset need not be erased; the next frame SHALL rewrite from address 0.

Structure
REQ-031 The state enum and the NUM_BYTES/ADDR_W defaults SHALL live in shared package snn_pkg.
REQ-032 The block SHALL be a single module with no sub-modules; the RAM and UART stay outside.

Verification
REQ-033 Send 98 bytes 0xA5 spaced 100 cycles apart -> address 0 gets bit 1, address 1 gets bit 0, ..., 784 writes total, last at address 783, one start_core pulse, overrun=0.
REQ-034 rx_rdy=0x01 then rx_rdy=0x80 three cycles later -> addresses 0..15 written on consecutive cycles with no gap; address 0=1 and address 15=1, all others 0.
REQ-035 Three rx_rdy pulses on consecutive cycles during UNPACK -> third byte dropped, overrun=1, count advances by 2 only.
REQ-036 Full frame, then rx_rdy in BUSY, with core_addr=0x155 -> ram_addr=0x155, ram_we=0, overrun=1; core_done -> WAIT, overrun=0, next byte written to address 0.
REQ-037 rst_n pulsed low after 40 bytes -> all outputs 0 immediately; a 98-byte frame afterwards gives exactly one start_core pulse, after byte 98.
